// File: rtl/hog_pkg.sv
// Shared HOG constants and width helpers for the cell/block stages.
package hog_pkg;
    localparam int CELL_SIZE            = 8;
    localparam int BINS                 = 9;
    localparam int BLOCK_CELLS          = 4;
    localparam int OUTPUT_BIN_WIDTH_DEF = 14;

    // Minimum of one bit so single-entry counters still have a register.
    function automatic int clog2(input int value);
        int bits;
        for (bits = 1; (1 << bits) < value; bits++) begin
        end
        return bits;
    endfunction

    function automatic int histogram_width(input int bin_width);
        return bin_width * BINS;
    endfunction

    function automatic int sum_width(input int bin_width);
        return bin_width + clog2(BLOCK_CELLS * BINS);
    endfunction
endpackage

// File: rtl/cell_line_buffer.sv
// One cell row of histograms: combinational read and synchronous write at the same column.
module cell_line_buffer
    import hog_pkg::*;
#(
    parameter int DEPTH = 80,
    parameter int WIDTH = 126,
    localparam int AW  = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             write_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data
);
    // Contents are deliberately unreset; row 0 of every frame rewrites them.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) mem[addr] <= write_data;
    end

    assign read_data = mem[addr];
endmodule

// File: rtl/block_assembler.sv
// Builds overlapping 2x2-cell HOG blocks from a raster cell-histogram stream.
// Define BLOCK_L1_SUM_EN to add the registered block_sum output.
module block_assembler
    import hog_pkg::*;
#(
    parameter int OUTPUT_BIN_WIDTH = OUTPUT_BIN_WIDTH_DEF,
    parameter int IMAGE_WIDTH      = 640,
    parameter int IMAGE_HEIGHT     = 480,
    localparam int CELLS_PER_ROW   = IMAGE_WIDTH / CELL_SIZE,
    localparam int CELL_ROWS       = IMAGE_HEIGHT / CELL_SIZE,
    localparam int HISTOGRAM_WIDTH = histogram_width(OUTPUT_BIN_WIDTH)
`ifdef BLOCK_L1_SUM_EN
    ,
    localparam int SUM_WIDTH       = sum_width(OUTPUT_BIN_WIDTH)
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [HISTOGRAM_WIDTH-1:0]   cell_histogram,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*HISTOGRAM_WIDTH-1:0] block_histogram
`ifdef BLOCK_L1_SUM_EN
    ,
    output logic [SUM_WIDTH-1:0]         block_sum
`endif
);
    localparam int CW = clog2(CELLS_PER_ROW);
    localparam int RW = clog2(CELL_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(CELLS_PER_ROW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(CELL_ROWS - 1);

    logic [CW-1:0]              col;
    logic [RW-1:0]              row;
    logic [HISTOGRAM_WIDTH-1:0] left_top, left_bot, line_rd;
    logic                       accept, emit;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = (row != '0) && (col != '0);

    cell_line_buffer #(
        .DEPTH (CELLS_PER_ROW),
        .WIDTH (HISTOGRAM_WIDTH)
    ) u_line_buf (
        .clk        (clk),
        .write_en   (accept),
        .addr       (col),
        .write_data (cell_histogram),
        .read_data  (line_rd)
    );

`ifdef BLOCK_L1_SUM_EN
    logic [SUM_WIDTH-1:0] next_sum;

    always_comb begin
        next_sum = '0;
        for (int k = 0; k < BINS; k++) begin
            next_sum = next_sum
                + SUM_WIDTH'(left_top[k*OUTPUT_BIN_WIDTH +: OUTPUT_BIN_WIDTH])
                + SUM_WIDTH'(line_rd[k*OUTPUT_BIN_WIDTH +: OUTPUT_BIN_WIDTH])
                + SUM_WIDTH'(left_bot[k*OUTPUT_BIN_WIDTH +: OUTPUT_BIN_WIDTH])
                + SUM_WIDTH'(cell_histogram[k*OUTPUT_BIN_WIDTH +: OUTPUT_BIN_WIDTH]);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            block_histogram <= '0;
            col             <= '0;
            row             <= '0;
            left_top        <= '0;
            left_bot        <= '0;
`ifdef BLOCK_L1_SUM_EN
            block_sum       <= '0;
`endif
        end else if (accept) begin
            // An accept implies the old block is gone, so out_valid simply follows emit.
            out_valid <= emit;
            if (emit) begin
                block_histogram <= {left_top, line_rd, left_bot, cell_histogram};
`ifdef BLOCK_L1_SUM_EN
                block_sum       <= next_sum;
`endif
            end
            left_top <= line_rd;
            left_bot <= cell_histogram;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/block_assembler.md
Name: block_assembler

Overview:
- Downstream neighbour of the cell histogram stage. Consumes the raster-order stream of 9-bin cell histograms, one per 8x8 cell.
- Emits one 2x2-cell HOG block (36 bins) per cell position with row>=1 and col>=1, i.e. overlapping blocks with stride one cell.
- Holds the previous cell row in a one-row line buffer. Output feeds the block normalizer.
- Valid/ready on both sides.

Parameters:
- OUTPUT_BIN_WIDTH, 14, width of one cell bin.
- IMAGE_WIDTH, 640, image width in pixels.
- IMAGE_HEIGHT, 480, image height in pixels.
- CELLS_PER_ROW, IMAGE_WIDTH/8, cells per cell row (derived).
- CELL_ROWS, IMAGE_HEIGHT/8, cell rows per frame (derived).
- HISTOGRAM_WIDTH, OUTPUT_BIN_WIDTH*9, one cell histogram (derived).
- SUM_WIDTH, OUTPUT_BIN_WIDTH+6, width of the block L1 sum (derived; 36 bins).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  cell_histogram valid.
- in_ready  out  1  block accepts a cell.
- cell_histogram  in  HISTOGRAM_WIDTH  bin k at [k*OUTPUT_BIN_WIDTH +: OUTPUT_BIN_WIDTH].
- out_valid  out  1  block_histogram valid.
- out_ready  in  1  downstream accepts a block.
- block_histogram  out  4*HISTOGRAM_WIDTH  concatenation {TL, TR, BL, BR}, TL in the MSBs.
- block_sum  out  SUM_WIDTH  L1 sum of the 36 bins; present only with BLOCK_L1_SUM_EN.

Behaviour:
- Reset values: clk and rst as the codebase names them; reset is asynchronous and active-high. out_valid=0, block_histogram=0, block_sum=0, col counter=0, row counter=0, left registers=0. Line buffer contents are not reset.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, no bubble under continuous flow).
  - A cell is accepted when in_valid && in_ready.
  - A block is consumed when out_valid && out_ready.
  - While out_valid && !out_ready, block_histogram and block_sum hold stable and in_ready=0.
- On accept of cell (r,c):
  - TR = line_buf[c], which holds cell (r-1,c).
  - BR = incoming cell.
  - TL = left_top register, BL = left_bot register.
  - Then line_buf[c] <= incoming, left_top <= old line_buf[c], left_bot <= incoming.
- Emit condition: r>=1 && c>=1. block_histogram and out_valid are registered on the accept edge, so latency is exactly 1 cycle from accept to out_valid. If the emit condition is false, out_valid falls (when previously consumed) or stays 0.
- Counters:
  - c increments on every accept; wraps at CELLS_PER_ROW-1 to 0, and r increments.
  - r wraps at CELL_ROWS-1 to 0, which starts a new frame.
  - Row 0 only fills the line buffer. Column 0 only loads the left registers.
- Blocks per frame: (CELLS_PER_ROW-1)*(CELL_ROWS-1), in raster order.
- Arithmetic: block_sum is the unsigned sum of 36 bins with no saturation. The maximum is 36*(2^14-1) = 589788, which fits 20 bits.
- Frame boundary: no data from frame N appears in frame N+1 blocks, because row 0 of each frame emits nothing and overwrites the line buffer.
- Reset mid-frame: counters return to (0,0) and any pending output is dropped. The next accepted cell is treated as (0,0).
- Simultaneous events: consume and accept in the same cycle is legal; the new block replaces the old with out_valid held high.

Optional Feature:
- BLOCK_L1_SUM_EN defined:
  - block_sum port exists.
  - The sum is registered with block_histogram (same latency and stall behaviour).
  - Per-cell 9-bin partial sums may be pipelined alongside the cell data.
- Undefined: no block_sum port and no adder logic.

Decomposition:
- Shared package hog_pkg holds:
  - CELL_SIZE=8, BINS=9, BLOCK_CELLS=4.
  - OUTPUT_BIN_WIDTH default.
  - Function clog2 for counter widths.
  - Derived HISTOGRAM_WIDTH/SUM_WIDTH expressions.
- One sub-module, cell_line_buffer:
  - Depth CELLS_PER_ROW, width HISTOGRAM_WIDTH.
  - Combinational read at address c, write on accept.
  - Maps to registers or distributed RAM.

Test Plan (IMAGE_WIDTH=32, IMAGE_HEIGHT=24 -> 4x3 cells; cell n has every bin = n):
- Stream cells 0..11 with out_ready=1 -> exactly 6 blocks. The first follows accept of cell 5 by 1 cycle with TL=0, TR=1, BL=4, BR=5 and block_sum=90. The last has TL=6, TR=7, BL=10, BR=11 and block_sum=306.
- Same stream with out_ready low for 5 cycles after the first out_valid -> in_ready=0 and output held stable. After release, the block sequence is identical to the first scenario with no loss or duplication.
- Two back-to-back frames, second frame using cells 100..111 -> the second frame's first block is {100,101,104,105}, with no frame-1 values.
- All bins 16383 on all cells -> block_sum=589788 with no overflow.
- Assert rst after cell 6 accepted and mid-stall, then restart at cell 0 -> out_valid=0 immediately. The next block appears only after 6 new accepts.
- Random in_valid/out_ready gaps (50%) over 3 frames -> output matches the reference model block-for-block, and in_ready never equals 0 while out_valid=0.
